// File: rtl/memref_bank_responder_if.sv
// Bundle of the HIR memref port signals served by memref_bank_responder:
// kernel read port p0, kernel write port p1, load stream, dump stream, status.
// The slave modport is the responder's view; master is the harness/kernel side.
interface memref_bank_responder_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 8
);
    // Kernel read port
    logic              p0_addr_en;
    logic [ADDR_W-1:0] p0_addr_data;
    logic              p0_rd_en;
    logic [WIDTH-1:0]  p0_rd_data;
    logic              p0_rd_valid;
    // Kernel write port
    logic              p1_addr_en;
    logic [ADDR_W-1:0] p1_addr_data;
    logic              p1_wr_en;
    logic [WIDTH-1:0]  p1_wr_data;
    // Load stream
    logic              ld_valid;
    logic              ld_ready;
    logic [WIDTH-1:0]  ld_data;
    // Dump stream
    logic              dump_start;
    logic              dump_valid;
    logic              dump_ready;
    logic [WIDTH-1:0]  dump_data;
    logic              dump_last;
    // Status
    logic              busy;
    logic              err;

    modport slave (
        input  p0_addr_en, p0_addr_data, p0_rd_en,
        output p0_rd_data, p0_rd_valid,
        input  p1_addr_en, p1_addr_data, p1_wr_en, p1_wr_data,
        input  ld_valid, ld_data,
        output ld_ready,
        input  dump_start, dump_ready,
        output dump_valid, dump_data, dump_last,
        output busy, err
    );

    modport master (
        output p0_addr_en, p0_addr_data, p0_rd_en,
        input  p0_rd_data, p0_rd_valid,
        output p1_addr_en, p1_addr_data, p1_wr_en, p1_wr_data,
        output ld_valid, ld_data,
        input  ld_ready,
        output dump_start, dump_ready,
        input  dump_valid, dump_data, dump_last,
        input  busy, err
    );
endinterface

// File: rtl/memref_bank_responder.sv
// memref_bank_responder: DEPTH x WIDTH array serving one kernel read port (p0, latency 1)
// and one kernel write port (p1). Filled from a load stream (LOAD), used by the kernel (RUN),
// drained in address order to a valid/ready dump stream (DUMP).
// Optional feature macro: MEMREF_RESP_WR_FWD_EN -- same-address read+write in one RUN cycle
// returns the write data (write-first); otherwise the old array value is returned.
module memref_bank_responder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    memref_bank_responder_if.slave bus
);
    typedef enum logic [1:0] {StLoad, StRun, StDump} state_e;

    localparam logic [ADDR_W:0] LastPtr = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PtrOne  = (ADDR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    state_e            state_q;
    logic [ADDR_W:0]   ld_ptr_q;
    logic [ADDR_W:0]   rd_ptr_q;
    logic              rd_valid_q, rd_last_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic              skid_valid_q, skid_last_q;
    logic [WIDTH-1:0]  skid_data_q;
    logic              dump_valid_q, dump_last_q;
    logic [WIDTH-1:0]  dump_data_q;
    logic              p0_rd_valid_q;
    logic [WIDTH-1:0]  p0_rd_data_q;
    logic              err_q;

    logic              ld_ready, ld_fire;
    logic              kernel_rd, kernel_wr, rd_fwd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              dump_pop, dump_issue;
    logic [1:0]        held_next;
    logic              unused_addr_en;

    // Address strobes are accepted but carry no extra meaning here.
    assign unused_addr_en = bus.p0_addr_en ^ bus.p1_addr_en;

    assign ld_ready  = rst && (state_q == StLoad);
    assign ld_fire   = bus.ld_valid && ld_ready;
    assign kernel_rd = (state_q == StRun) && bus.p0_rd_en;
    assign kernel_wr = (state_q == StRun) && bus.p1_wr_en;

`ifdef MEMREF_RESP_WR_FWD_EN
    assign rd_fwd = kernel_wr && (bus.p1_addr_data == bus.p0_addr_data);
`else
    assign rd_fwd = 1'b0;
`endif

    // Single array write port, shared by the load stream and kernel port p1.
    always_comb begin
        mem_we    = ld_fire || kernel_wr;
        mem_waddr = ld_fire ? ld_ptr_q[ADDR_W-1:0] : bus.p1_addr_data;
        mem_wdata = ld_fire ? bus.ld_data : bus.p1_wr_data;
    end

    // Dump read issue: only launch a read if output+skid can absorb it next cycle.
    always_comb begin
        dump_pop   = dump_valid_q && bus.dump_ready;
        held_next  = {1'b0, dump_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_valid_q}
                   - {1'b0, dump_pop};
        dump_issue = (state_q == StDump) && !rd_ptr_q[ADDR_W] && (held_next <= 2'd1);
    end

    // Array storage; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM, kernel read register, dump pipeline and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StLoad;
            ld_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_data_q     <= '0;
            skid_valid_q  <= 1'b0;
            skid_last_q   <= 1'b0;
            skid_data_q   <= '0;
            dump_valid_q  <= 1'b0;
            dump_last_q   <= 1'b0;
            dump_data_q   <= '0;
            p0_rd_valid_q <= 1'b0;
            p0_rd_data_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            p0_rd_valid_q <= kernel_rd;
            if (kernel_rd) begin
                p0_rd_data_q <= rd_fwd ? bus.p1_wr_data : mem_q[bus.p0_addr_data];
            end
            if ((bus.p0_rd_en || bus.p1_wr_en) && (state_q != StRun)) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                StLoad: begin
                    if (ld_fire) begin
                        ld_ptr_q <= ld_ptr_q + PtrOne;
                        if (ld_ptr_q == LastPtr) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (bus.dump_start) begin
                        state_q <= StDump;
                    end
                end
                StDump: begin
                    rd_valid_q <= dump_issue;
                    if (dump_issue) begin
                        rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                        rd_last_q <= (rd_ptr_q == LastPtr);
                        rd_ptr_q  <= rd_ptr_q + PtrOne;
                    end
                    // Output register refills from skid first, then from the read stage.
                    if (!dump_valid_q || dump_pop) begin
                        if (skid_valid_q) begin
                            dump_valid_q <= 1'b1;
                            dump_data_q  <= skid_data_q;
                            dump_last_q  <= skid_last_q;
                            skid_valid_q <= rd_valid_q;
                            skid_data_q  <= rd_data_q;
                            skid_last_q  <= rd_last_q;
                        end else if (rd_valid_q) begin
                            dump_valid_q <= 1'b1;
                            dump_data_q  <= rd_data_q;
                            dump_last_q  <= rd_last_q;
                        end else begin
                            dump_valid_q <= 1'b0;
                            dump_last_q  <= 1'b0;
                        end
                    end else if (rd_valid_q) begin
                        skid_valid_q <= 1'b1;
                        skid_data_q  <= rd_data_q;
                        skid_last_q  <= rd_last_q;
                    end
                    if (dump_pop && dump_last_q) begin
                        state_q  <= StRun;
                        rd_ptr_q <= '0;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign bus.ld_ready    = ld_ready;
    assign bus.p0_rd_data  = p0_rd_data_q;
    assign bus.p0_rd_valid = p0_rd_valid_q;
    assign bus.dump_valid  = dump_valid_q;
    assign bus.dump_data   = dump_data_q;
    assign bus.dump_last   = dump_last_q;
    assign bus.busy        = (state_q != StRun);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_memref_bank_responder.sv
// Directed bench for memref_bank_responder: load, kernel read/write, same-address access,
// stalled and full-rate dump, kernel access outside RUN, reset during load.
module tb_memref_bank_responder;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [31:0] exp_mem [256];

`ifdef MEMREF_RESP_WR_FWD_EN
    localparam logic [31:0] ExpSame = 32'hDEAD;
`else
    localparam logic [31:0] ExpSame = 32'd7;
`endif

    memref_bank_responder_if bus ();

    memref_bank_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic do_load(input logic [31:0] base, input int n, input bit gap, output int acc);
        int cyc;
        bit hs;
        cyc = 0;
        acc = 0;
        while (acc < n && cyc < 4 * n + 16) begin
            bus.ld_valid = gap ? (cyc % 2 == 0) : 1'b1;
            bus.ld_data  = base + 32'(acc);
            hs = bus.ld_valid && bus.ld_ready;
            cycle();
            cyc++;
            if (hs) acc++;
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) cycle();
        tests_run++;
        if (bus.busy !== 1'b1 || bus.ld_ready !== 1'b0 || bus.err !== 1'b0 ||
            bus.dump_valid !== 1'b0 || bus.dump_last !== 1'b0 || bus.dump_data !== 32'd0 ||
            bus.p0_rd_valid !== 1'b0 || bus.p0_rd_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b ld_ready=%b err=%b dv=%b dl=%b dd=%0h rv=%b rd=%0h",
                     bus.busy, bus.ld_ready, bus.err, bus.dump_valid, bus.dump_last,
                     bus.dump_data, bus.p0_rd_valid, bus.p0_rd_data);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.ld_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ld_ready: got %b expected 1", bus.ld_ready);
        end
    endtask

    task automatic test_load();
        int acc;
        for (int i = 0; i < 256; i++) exp_mem[i] = 32'(i);
        do_load(32'd0, 255, 1'b1, acc);
        chk("load_255_accepts", 32'(acc), 32'd255);
        chk("load_busy_before_last", {31'd0, bus.busy}, 32'd1);
        chk("load_ready_before_last", {31'd0, bus.ld_ready}, 32'd1);
        do_load(32'd255, 1, 1'b1, acc);
        chk("load_last_accept", 32'(acc), 32'd1);
        chk("load_busy_after_last", {31'd0, bus.busy}, 32'd0);
        chk("load_ready_after_last", {31'd0, bus.ld_ready}, 32'd0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hFFFF_FFFF;
        cycle();
        chk("load_no_extra_beat", {31'd0, bus.ld_ready}, 32'd0);
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_read();
        bus.p0_addr_data = 8'd5;
        bus.p0_rd_en     = 1'b1;
        cycle();
        bus.p0_rd_en = 1'b0;
        chk("read5_valid", {31'd0, bus.p0_rd_valid}, 32'd1);
        chk("read5_data", bus.p0_rd_data, 32'd5);
        cycle();
        chk("read5_valid_drop", {31'd0, bus.p0_rd_valid}, 32'd0);
        chk("read5_data_hold", bus.p0_rd_data, 32'd5);
        bus.p0_addr_data = 8'd0;
        bus.p0_rd_en     = 1'b1;
        cycle();
        chk("read0_data", bus.p0_rd_data, 32'd0);
        bus.p0_addr_data = 8'd255;
        cycle();
        bus.p0_rd_en = 1'b0;
        chk("read255_valid", {31'd0, bus.p0_rd_valid}, 32'd1);
        chk("read255_data", bus.p0_rd_data, 32'd255);
    endtask

    task automatic test_same_addr();
        bus.p1_addr_data = 8'd7;
        bus.p1_wr_data   = 32'hDEAD;
        bus.p1_wr_en     = 1'b1;
        bus.p0_addr_data = 8'd7;
        bus.p0_rd_en     = 1'b1;
        cycle();
        bus.p1_wr_en = 1'b0;
        exp_mem[7] = 32'hDEAD;
        chk("same_addr_rd", bus.p0_rd_data, ExpSame);
        cycle();
        chk("same_addr_next_rd", bus.p0_rd_data, 32'hDEAD);
        // Different-address write alongside a read.
        bus.p1_addr_data = 8'd200;
        bus.p1_wr_data   = 32'h1234_5678;
        bus.p1_wr_en     = 1'b1;
        bus.p0_addr_data = 8'd5;
        cycle();
        bus.p1_wr_en = 1'b0;
        exp_mem[200] = 32'h1234_5678;
        chk("diff_addr_rd5", bus.p0_rd_data, 32'd5);
        bus.p0_addr_data = 8'd200;
        cycle();
        bus.p0_rd_en = 1'b0;
        chk("diff_addr_rd200", bus.p0_rd_data, 32'h1234_5678);
    endtask

    task automatic test_dump_stall();
        logic        pat [4];
        int          beat, cyc, first_valid;
        bit          stalled;
        logic [31:0] prev_data;
        logic        prev_last;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        chk("err_clear_before_dump", {31'd0, bus.err}, 32'd0);
        bus.dump_start = 1'b1;
        cycle();
        bus.dump_start = 1'b0;
        chk("dump_entry_busy", {31'd0, bus.busy}, 32'd1);
        beat = 0; cyc = 0; first_valid = -1; stalled = 0;
        prev_data = '0; prev_last = 1'b0;
        while (beat < 256 && cyc < 3000) begin
            bus.dump_ready = pat[cyc % 4];
            if (bus.dump_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                tests_run++;
                if (bus.dump_valid !== 1'b1 || bus.dump_data !== prev_data ||
                    bus.dump_last !== prev_last) begin
                    tests_failed++;
                    $display("FAIL dump_stall_hold beat %0d: v=%b d=%0h l=%b expected v=1 d=%0h l=%b",
                             beat, bus.dump_valid, bus.dump_data, bus.dump_last,
                             prev_data, prev_last);
                end
            end
            if (bus.dump_valid === 1'b1 && bus.dump_ready === 1'b1) begin
                tests_run++;
                if (bus.dump_data !== exp_mem[beat] || bus.dump_last !== (beat == 255)) begin
                    tests_failed++;
                    $display("FAIL dump_beat %0d: d=%0h l=%b expected d=%0h l=%b", beat,
                             bus.dump_data, bus.dump_last, exp_mem[beat], (beat == 255));
                end
                beat++;
                stalled = 0;
            end else if (bus.dump_valid === 1'b1) begin
                stalled   = 1;
                prev_data = bus.dump_data;
                prev_last = bus.dump_last;
            end else begin
                stalled = 0;
            end
            cycle();
            cyc++;
        end
        bus.dump_ready = 1'b0;
        chk("dump_beat_count", 32'(beat), 32'd256);
        tests_run++;
        if (first_valid < 0 || first_valid > 2) begin
            tests_failed++;
            $display("FAIL dump_first_valid: got cycle %0d expected <= 2", first_valid);
        end
        chk("dump_done_busy", {31'd0, bus.busy}, 32'd0);
        chk("dump_done_valid", {31'd0, bus.dump_valid}, 32'd0);
    endtask

    task automatic test_kernel_in_dump();
        int beat, cyc;
        bus.dump_start = 1'b1;
        cycle();
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b1;
        beat = 0; cyc = 0;
        while (beat < 256 && cyc < 1000) begin
            bus.p0_rd_en     = (cyc < 5);
            bus.p0_addr_data = 8'd5;
            bus.p1_wr_en     = (cyc < 5);
            bus.p1_addr_data = 8'd3;
            bus.p1_wr_data   = 32'hBAD;
            if (cyc < 7) begin
                tests_run++;
                if (bus.p0_rd_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL dump_no_rd_valid cyc %0d: got %b expected 0", cyc,
                             bus.p0_rd_valid);
                end
            end
            if (bus.dump_valid === 1'b1) begin
                tests_run++;
                if (bus.dump_data !== exp_mem[beat] || bus.dump_last !== (beat == 255)) begin
                    tests_failed++;
                    $display("FAIL dump_fullrate_beat %0d: d=%0h l=%b expected d=%0h l=%b",
                             beat, bus.dump_data, bus.dump_last, exp_mem[beat], (beat == 255));
                end
                beat++;
            end
            cycle();
            cyc++;
        end
        bus.p0_rd_en   = 1'b0;
        bus.p1_wr_en   = 1'b0;
        bus.dump_ready = 1'b0;
        chk("dump_fullrate_count", 32'(beat), 32'd256);
        tests_run++;
        if (cyc > 258) begin
            tests_failed++;
            $display("FAIL dump_fullrate_cycles: got %0d expected <= 258", cyc);
        end
        chk("err_sticky_set", {31'd0, bus.err}, 32'd1);
        bus.p0_addr_data = 8'd3;
        bus.p0_rd_en     = 1'b1;
        cycle();
        bus.p0_rd_en = 1'b0;
        chk("no_write_in_dump", bus.p0_rd_data, exp_mem[3]);
        chk("err_still_set", {31'd0, bus.err}, 32'd1);
    endtask

    task automatic test_reset_midload();
        int acc;
        rst = 1'b0;
        cycle();
        chk("rst_ld_ready_low", {31'd0, bus.ld_ready}, 32'd0);
        rst = 1'b1;
        cycle();
        chk("rst_err_cleared", {31'd0, bus.err}, 32'd0);
        do_load(32'h100, 10, 1'b0, acc);
        chk("midload_10_beats", 32'(acc), 32'd10);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        chk("midload_busy", {31'd0, bus.busy}, 32'd1);
        chk("midload_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("midload_err", {31'd0, bus.err}, 32'd0);
        do_load(32'h200, 256, 1'b0, acc);
        chk("reload_count", 32'(acc), 32'd256);
        chk("reload_busy", {31'd0, bus.busy}, 32'd0);
        bus.p0_rd_en     = 1'b1;
        bus.p0_addr_data = 8'd0;
        cycle();
        chk("reload_addr0", bus.p0_rd_data, 32'h200);
        bus.p0_addr_data = 8'd9;
        cycle();
        chk("reload_addr9", bus.p0_rd_data, 32'h209);
        bus.p0_addr_data = 8'd255;
        cycle();
        bus.p0_rd_en = 1'b0;
        chk("reload_addr255", bus.p0_rd_data, 32'h2FF);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        bus.p0_addr_en = 1'b0; bus.p0_addr_data = '0; bus.p0_rd_en = 1'b0;
        bus.p1_addr_en = 1'b0; bus.p1_addr_data = '0; bus.p1_wr_en = 1'b0;
        bus.p1_wr_data = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0;
        bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
        test_reset();
        test_load();
        test_read();
        test_same_addr();
        test_dump_stall();
        test_kernel_in_dump();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
